// File: rtl/memory_stage_control.sv
// Memory-stage controller and M/W pipeline latch: issues lw/sw over a req/ack handshake, stalls while busy.
// Optional feature MEM_TIMEOUT_EN: abort an access after TIMEOUT cycles without ack and set a sticky error.
module memory_stage_control #(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [31:0]       insn_in,
   input  logic [31:0]       alu_in,
   input  logic [31:0]       store_in,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              valid_out,
   output logic [31:0]       insn_out,
   output logic [31:0]       alu_out,
   output logic [31:0]       dmem_out,
   output logic              error
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [4:0] OP_LW = 5'b01000;
   localparam logic [4:0] OP_SW = 5'b00111;

   state_t state, state_nx;

   logic [4:0] opcode;
   logic       is_lw, is_sw, memop;
   logic       timeout_hit;

   logic [31:0] held_insn, held_alu;
   logic        held_lw;
   logic        capture;

   logic              req_nx, we_nx, vld_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [31:0]       wdata_nx, insn_nx, alu_nx, dmem_nx;

   assign opcode = insn_in[31:27];
   assign is_lw  = (opcode == OP_LW);
   assign is_sw  = (opcode == OP_SW);
   assign memop  = valid_in & (is_lw | is_sw);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (memop) state_nx = BUSY;
         BUSY:    if (mem_ack || timeout_hit) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output decode: stall plus next values for the request and M/W registers.
   always_comb begin
      stall    = 1'b0;
      capture  = 1'b0;
      req_nx   = 1'b0;
      we_nx    = mem_we;
      addr_nx  = mem_addr;
      wdata_nx = mem_wdata;
      vld_nx   = 1'b0;
      insn_nx  = '0;
      alu_nx   = '0;
      dmem_nx  = '0;
      case (state)
         IDLE: begin
            stall = memop;
            if (memop) begin
               capture  = 1'b1;
               req_nx   = 1'b1;
               we_nx    = is_sw;
               addr_nx  = alu_in[ADDR_W-1:0];
               wdata_nx = store_in;
            end else begin
               vld_nx  = valid_in;
               insn_nx = insn_in;
               alu_nx  = alu_in;
            end
         end
         BUSY: begin
            stall  = 1'b1;
            req_nx = 1'b1;
            if (mem_ack) begin
               req_nx  = 1'b0;
               vld_nx  = 1'b1;
               insn_nx = held_insn;
               alu_nx  = held_alu;
               dmem_nx = held_lw ? mem_rdata : 32'd0;
            end else if (timeout_hit) begin
               req_nx  = 1'b0;
               vld_nx  = 1'b1;
               insn_nx = held_insn;
               alu_nx  = held_alu;
            end
         end
         default: ;
      endcase
   end

   // Stage boundary: memory request and M/W latch
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         valid_out <= 1'b0;
         insn_out  <= '0;
         alu_out   <= '0;
         dmem_out  <= '0;
      end else begin
         mem_req   <= req_nx;
         mem_we    <= we_nx;
         mem_addr  <= addr_nx;
         mem_wdata <= wdata_nx;
         valid_out <= vld_nx;
         insn_out  <= insn_nx;
         alu_out   <= alu_nx;
         dmem_out  <= dmem_nx;
      end
   end

   // Instruction parked while the access is outstanding
   always_ff @(posedge clock) begin
      if (capture) begin
         held_insn <= insn_in;
         held_alu  <= alu_in;
         held_lw   <= is_lw;
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)             wait_cnt <= '0;
      else if (state == IDLE) wait_cnt <= '0;
      else if (!mem_ack)      wait_cnt <= wait_cnt + 1'b1;
   end

   // An ack arriving on the final cycle takes priority over the abort.
   assign timeout_hit = (state == BUSY) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)           error <= 1'b0;
      else if (timeout_hit) error <= 1'b1;
   end
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT > 0);
   assign timeout_hit    = 1'b0;
   assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage_control.sv
// Bench for memory_stage_control: vector table plus hand sequences, results checked through a scoreboard queue.
module tb_memory_stage_control;
   localparam int ADDR_W = 12;
   localparam logic [4:0] OP_LW = 5'b01000;
   localparam logic [4:0] OP_SW = 5'b00111;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              valid_in;
   logic [31:0]       insn_in, alu_in, store_in;
   logic              stall;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;
   logic              mem_ack;
   logic              valid_out;
   logic [31:0]       insn_out, alu_out, dmem_out;
   logic              error;

   always #5 clk = ~clk;

   memory_stage_control #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
      .clock(clk), .reset(rst_n), .valid_in(valid_in), .insn_in(insn_in), .alu_in(alu_in),
      .store_in(store_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .valid_out(valid_out),
      .insn_out(insn_out), .alu_out(alu_out), .dmem_out(dmem_out), .error(error)
   );

   typedef struct {
      logic [31:0] insn;
      logic [31:0] alu;
      logic [31:0] dmem;
      logic        chk_alu;
   } exp_t;

   typedef struct {
      logic        vin;
      logic [31:0] insn;
      logic [31:0] alu;
      logic [31:0] store;
      logic [31:0] rdata;
      int          waits;
      logic        exp_stall;
      logic        exp_we;
      logic [31:0] exp_dmem;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[8];
   int   checks = 0;
   int   errors = 0;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] insn, input logic [31:0] alu,
                           input logic [31:0] dmem, input logic chk_alu);
      exp_t e;
      e.insn    = insn;
      e.alu     = alu;
      e.dmem    = dmem;
      e.chk_alu = chk_alu;
      sb.push_back(e);
   endtask

   // Scoreboard: every valid M/W result must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && valid_out) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: valid_out with insn %h, expected no result", insn_out);
         end else begin
            e = sb.pop_front();
            check32("sb_insn", insn_out, e.insn);
            if (e.chk_alu) check32("sb_alu", alu_out, e.alu);
            check32("sb_dmem", dmem_out, e.dmem);
         end
      end
   end

   task automatic run_vec(input vec_t v, input string tag);
      valid_in = v.vin;
      insn_in  = v.insn;
      alu_in   = v.alu;
      store_in = v.store;
      mem_ack  = 1'b0;
      #1;
      check1({tag, "_stall"}, stall, v.exp_stall);
      if (!v.exp_stall) begin
         if (v.vin) push_exp(v.insn, v.alu, 32'd0, 1'b1);
         @(posedge clk); #1;
         check1({tag, "_noreq"}, mem_req, 1'b0);
      end else begin
         @(posedge clk); #1;
         check1({tag, "_req"}, mem_req, 1'b1);
         check1({tag, "_we"}, mem_we, v.exp_we);
         check32({tag, "_addr"}, 32'(mem_addr), 32'(v.alu[ADDR_W-1:0]));
         check32({tag, "_wdata"}, mem_wdata, v.store);
         check1({tag, "_bubble_vld"}, valid_out, 1'b0);
         check32({tag, "_bubble_insn"}, insn_out, 32'd0);
         // Scramble X/M while busy; the held copy must be used.
         valid_in = 1'b1;
         insn_in  = 32'h0000_0001;
         alu_in   = $urandom;
         store_in = $urandom;
         for (int w = 0; w < v.waits; w++) begin
            #1;
            check1({tag, "_wait_stall"}, stall, 1'b1);
            @(posedge clk); #1;
            check1({tag, "_wait_req"}, mem_req, 1'b1);
            check1({tag, "_wait_we"}, mem_we, v.exp_we);
            check32({tag, "_wait_addr"}, 32'(mem_addr), 32'(v.alu[ADDR_W-1:0]));
            check32({tag, "_wait_wdata"}, mem_wdata, v.store);
            check1({tag, "_wait_vld"}, valid_out, 1'b0);
         end
         mem_ack   = 1'b1;
         mem_rdata = v.rdata;
         push_exp(v.insn, v.alu, v.exp_dmem, 1'b1);
         #1;
         check1({tag, "_ack_stall"}, stall, 1'b1);
         @(posedge clk); #1;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         check1({tag, "_req_drop"}, mem_req, 1'b0);
      end
   endtask

   initial begin
      // vin, insn, alu, store, rdata, waits, exp_stall, exp_we, exp_dmem
      vecs[0] = '{1'b1, {5'b00000, 27'h0000010}, 32'h0000_0005, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{1'b1, {OP_LW, 27'h0012345}, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, {OP_SW, 27'h0000ABC}, 32'h0000_0024, 32'h1234_5678, 32'hFFFF_0000, 3, 1'b1, 1'b1, 32'h0};
      vecs[3] = '{1'b1, {OP_LW, 27'h0000001}, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'hCAFE_F00D};
      vecs[4] = '{1'b1, {OP_LW, 27'h0000002}, 32'hABCD_E123, 32'h0, 32'h0BAD_F00D, 1, 1'b1, 1'b0, 32'h0BAD_F00D};
      vecs[5] = '{1'b0, {OP_LW, 27'h0000003}, 32'h0000_0044, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{1'b1, {OP_SW, 27'h0000004}, 32'h0000_03FC, 32'hA5A5_5A5A, 32'h1111_1111, 0, 1'b1, 1'b1, 32'h0};
      vecs[7] = '{1'b1, {5'b01001, 27'h0000005}, 32'h0000_0077, 32'h9, 32'h0, 0, 1'b0, 1'b0, 32'h0};

      // Reset held with a live lw presented
      rst_n     = 1'b0;
      valid_in  = 1'b1;
      insn_in   = {OP_LW, 27'h0012345};
      alu_in    = 32'h0000_0010;
      store_in  = 32'h7777_7777;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check1("rst_req", mem_req, 1'b0);
      check1("rst_we", mem_we, 1'b0);
      check32("rst_addr", 32'(mem_addr), 32'd0);
      check32("rst_wdata", mem_wdata, 32'd0);
      check1("rst_vld", valid_out, 1'b0);
      check32("rst_insn", insn_out, 32'd0);
      check32("rst_alu", alu_out, 32'd0);
      check32("rst_dmem", dmem_out, 32'd0);
      check1("rst_error", error, 1'b0);
      rst_n = 1'b1;
      run_vec(vecs[1], "rst_rel");

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Spurious ack while idle
      valid_in  = 1'b1;
      insn_in   = 32'h0000_0099;
      alu_in    = 32'h0000_0099;
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      push_exp(32'h0000_0099, 32'h0000_0099, 32'd0, 1'b1);
      #1;
      check1("spur_stall", stall, 1'b0);
      @(posedge clk); #1;
      check1("spur_req", mem_req, 1'b0);
      valid_in = 1'b0;
      @(posedge clk); #1;
      check1("spur_req2", mem_req, 1'b0);
      check1("spur_vld2", valid_out, 1'b0);
      mem_ack = 1'b0;

      // Reset in the middle of an access
      valid_in = 1'b1;
      insn_in  = {OP_LW, 27'h0000055};
      alu_in   = 32'h0000_0055;
      @(posedge clk); #1;
      check1("mid_req", mem_req, 1'b1);
      valid_in = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check1("mid_req_async", mem_req, 1'b0);
      check1("mid_vld", valid_out, 1'b0);
      mem_ack = 1'b1;
      @(posedge clk); #1;
      check1("mid_vld2", valid_out, 1'b0);
      mem_ack = 1'b0;
      rst_n   = 1'b1;
      #1;
      check1("mid_stall", stall, 1'b0);
      run_vec(vecs[0], "post_rst");

`ifdef MEM_TIMEOUT_EN
      // No ack: abort after four busy cycles
      valid_in = 1'b1;
      insn_in  = {OP_LW, 27'h0000066};
      alu_in   = 32'h0000_0066;
      @(posedge clk); #1;
      check1("to_req", mem_req, 1'b1);
      valid_in = 1'b0;
      for (int i = 1; i < 4; i++) begin
         @(posedge clk); #1;
         check1($sformatf("to_wait%0d_req", i), mem_req, 1'b1);
         check1($sformatf("to_wait%0d_err", i), error, 1'b0);
      end
      push_exp({OP_LW, 27'h0000066}, 32'h0000_0066, 32'd0, 1'b0);
      @(posedge clk); #1;
      check1("to_abort_req", mem_req, 1'b0);
      check1("to_abort_err", error, 1'b1);
      check1("to_abort_vld", valid_out, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check1("to_err_sticky", error, 1'b1);
`else
      check1("no_feature_error", error, 1'b0);
`endif

      valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check32("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/memory_stage_control.md
Name: memory_stage_control

Overview:
- Memory-stage controller and M/W pipeline latch for the 5-stage pipeline.
- Takes the X/M instruction and ALU result, then runs loads and stores against data memory through a req/ack handshake.
- Holds the pipeline with a stall while an access is outstanding.
- Presents insn, ALU data and memory read data to writeback control with a valid flag.

Parameters:
ADDR_W, 12, data-memory word address width; mem_addr = alu_in[ADDR_W-1:0]
TIMEOUT, 64, cycles to wait for mem_ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
valid_in  in  1  X/M latch holds a live instruction
insn_in  in  32  X/M instruction; opcode = insn_in[31:27]
alu_in  in  32  ALU result (effective address for lw/sw)
store_in  in  32  store data (rd value) for sw
stall  out  1  combinational; hold fetch/decode/execute and X/M latch
mem_req  out  1  registered; access request to data memory
mem_we  out  1  registered; 1 = write (sw), 0 = read (lw)
mem_addr  out  ADDR_W  registered word address
mem_wdata  out  32  registered store data
mem_rdata  in  32  read data, valid when mem_ack=1
mem_ack  in  1  single-cycle completion pulse from memory
valid_out  out  1  M/W latch holds a live instruction
insn_out  out  32  M/W instruction to writeback
alu_out  out  32  M/W ALU result
dmem_out  out  32  M/W memory read data (0 for non-loads)
error  out  1  sticky timeout flag (0 when feature absent)

Behaviour:
- Decode rules:
  - lw: opcode 01000.
  - sw: opcode 00111.
  - memop = valid_in & (lw | sw).
- Reset (reset=0, async):
  - State goes to IDLE.
  - All registered outputs go to 0: mem_req, mem_we, mem_addr, mem_wdata, valid_out, insn_out, alu_out, dmem_out, error.
  - A reset during BUSY drops mem_req immediately. The in-flight access is discarded with no writeback.
- IDLE:
  - stall = memop.
  - Non-memop edge: the M/W latch loads valid_in, insn_in, alu_in, and dmem_out=0. Latency is 1 cycle.
  - memop edge:
    - Latch mem_addr, mem_wdata=store_in, mem_we=sw, mem_req=1.
    - Hold insn and alu internally.
    - M/W gets a bubble (valid_out=0, insn_out=0).
    - Next state is BUSY.
  - mem_ack in IDLE is ignored.
- BUSY:
  - stall=1.
  - mem_req, mem_we, mem_addr and mem_wdata hold stable.
  - Each cycle without mem_ack loads a bubble into M/W.
  - Edge with mem_ack=1:
    - mem_req goes to 0.
    - M/W loads the held insn and alu with valid_out=1.
    - dmem_out gets mem_rdata for lw and 0 for sw.
    - Next state is IDLE.
  - The cycle after, stall deasserts and the next X/M instruction is evaluated normally.
  - Back-to-back memops therefore each take their own IDLE→BUSY round trip.
- Latency:
  - Minimum memop latency, X/M presentation to valid_out, is 2 cycles (ack in the first BUSY cycle).
  - Each extra wait cycle adds 1.
- X/M inputs are ignored in BUSY; the upstream stall guarantees they are stable.
- mem_req is never asserted in two consecutive cycles across separate instructions: there is always ≥1 IDLE cycle with mem_req=0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT-1 without ack, the block aborts:
    - mem_req goes to 0 and state returns to IDLE.
    - M/W loads the held insn with valid_out=1 and dmem_out=0.
    - error is set and stays 1 until reset.
  - An ack in the same cycle as the timeout wins (normal completion, error unchanged).
- Undefined:
  - No counter; BUSY waits indefinitely.
  - error is tied to 0.

Test Plan:
- Reset: hold reset=0 with valid_in=1 and insn=lw → all outputs 0. Release → next edge issues mem_req=1.
- Non-memop: add insn (opcode 00000), alu_in=0x0000_0005 → next cycle valid_out=1, alu_out=5, dmem_out=0, stall=0 throughout.
- Load with immediate ack:
  - Stimulus: lw, alu_in=0x0000_0010; mem_ack=1 with mem_rdata=0xDEAD_BEEF in the first BUSY cycle.
  - Required: mem_addr=0x010, mem_we=0; stall high for 2 cycles; valid_out=1 with dmem_out=0xDEAD_BEEF 2 cycles after presentation.
- Store with 3 wait cycles:
  - Stimulus: sw, store_in=0x1234_5678.
  - Required: mem_we=1 and mem_wdata stable for 4 BUSY cycles; bubbles in M/W while waiting; valid_out=1 with dmem_out=0 after ack; mem_req=0 next cycle.
- Back-to-back lw,lw → two separate req pulses separated by ≥1 cycle with mem_req=0; both results appear in order. Spurious ack in IDLE → no effect.
- Mid-access reset, with MEM_TIMEOUT_EN and TIMEOUT=4:
  - Reset during BUSY → mem_req drops asynchronously, no valid_out.
  - Separately, no ack → abort after 4 BUSY cycles, error=1, valid_out=1, dmem_out=0.
